// File: rtl/anim_frame_timer_pkg.sv
// Shared types and defaults for the animation frame timer.
package anim_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ZDONE = 2'd2
  } state_e;

  localparam int DEFAULT_TICK_DIV = 833334;
  localparam int DEFAULT_FRAME_W  = 4;

endpackage

// File: rtl/anim_frame_timer_tick_prescaler.sv
// Clock prescaler for the frame timer: counts 0..TICK_DIV-1 while run is
// high and flags the cycle on which it wraps. clear wins over run.
module tick_prescaler
  import anim_timer_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic wrap
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Combinational wrap flag; the top level registers it into frame_tick.
  assign wrap = run && !clear && (cnt_q == CNT_LAST);

  // Next count: hold, advance, wrap to zero, or clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/anim_frame_timer.sv
// Frame-rate timer for sprite/claw animations: divides clk into frame ticks,
// counts a latched number of frames, pulses done at the end of the sequence,
// one-shot or repeating. Optional pause input enabled by defining
// ANIM_FRAME_TIMER_PAUSE_EN; without it the timer runs continuously.
module anim_frame_timer
  import anim_timer_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int FRAME_W  = DEFAULT_FRAME_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               repeat_mode,
  input  logic [FRAME_W-1:0] frames,
`ifdef ANIM_FRAME_TIMER_PAUSE_EN
  input  logic               pause,
`endif
  output logic               busy,
  output logic               frame_tick,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               done
);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] frames_q, frames_d;
  logic               rep_q, rep_d;
  logic               busy_q, busy_d;
  logic               tick_q, tick_d;
  logic [FRAME_W-1:0] idx_q, idx_d;
  logic               done_q, done_d;

  logic hold;
  logic presc_run;
  logic presc_clear;
  logic wrap;
  logic accept;
  logic last_frame;

`ifdef ANIM_FRAME_TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // Prescaler stays at zero outside RUN so every sequence starts phase-aligned.
  assign presc_run   = (state_q == RUN) && !hold;
  assign presc_clear = (state_q != RUN) || abort;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .run  (presc_run),
    .clear(presc_clear),
    .wrap (wrap)
  );

  assign accept     = start && !abort;
  assign last_frame = (idx_q == frames_q - FRAME_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (frames == '0) ? ZDONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (wrap && last_frame && !rep_q) begin
          state_d = IDLE;
        end
      end
      ZDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; tick/done are pulses, the rest hold.
  always_comb begin
    frames_d = frames_q;
    rep_d    = rep_q;
    busy_d   = busy_q;
    idx_d    = idx_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && (frames != '0)) begin
          frames_d = frames;
          rep_d    = repeat_mode;
          idx_d    = '0;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          busy_d = 1'b0;
          idx_d  = '0;
        end else if (wrap) begin
          tick_d = 1'b1;
          if (last_frame) begin
            done_d = 1'b1;
            if (rep_q) begin
              idx_d = '0;
            end else begin
              busy_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + FRAME_W'(1);
          end
        end
      end
      ZDONE:   done_d = 1'b1;
      default: ;
    endcase
  end

  // Registered outputs and latched sequence parameters.
  always_ff @(posedge clk) begin
    if (reset) begin
      frames_q <= '0;
      rep_q    <= 1'b0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      frames_q <= frames_d;
      rep_q    <= rep_d;
      busy_q   <= busy_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

  assign busy       = busy_q;
  assign frame_tick = tick_q;
  assign frame_idx  = idx_q;
  assign done       = done_q;

endmodule
